csr_uart_char: RTL and testbench

// - CSR-mapped 8N1 UART, one character per CSR access, on the pipeline's shared CSR bus.
// - One CSR register at BASE_ADDR. Software writes a byte to transmit and polls the same CSR for status and received bytes.
// - rdata is zero when not addressed, so it can be OR-ed with other CSR slaves (counters, pin outputs).

---
 rtl/csr_uart_char.sv | 194 +++++++++++++++++++
 tb/tb_csr_uart_char.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_uart_char.sv
`default_nettype none
// ============================================================================
// Module   : csr_uart_char
// Purpose  : One-register CSR-mapped 8N1 UART (TX always, RX when
//            CSR_UART_RX_EN is defined); rdata is zero when not selected.
// Revision : 1.0 - initial release
// ============================================================================
module csr_uart_char #(
    parameter int          CLOCK_RATE = 100_000_000,
    parameter int          BAUD_RATE  = 115200,
    parameter logic [11:0] BASE_ADDR  = 12'hBC0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        read,
    input  logic [2:0]  modify,
    input  logic [31:0] wdata,
    input  logic [11:0] addr,
    output logic [31:0] rdata,
    output logic        valid,
    input  logic        rx,
    output logic        tx
);

    localparam int            DIV       = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] BAUD_HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

    logic       sel;
    logic       tx_busy;
    logic       rx_full;
    logic [7:0] rx_byte;
    logic       unused_wdata;

    assign sel          = (addr == BASE_ADDR) && (read || (modify != 3'b000));
    assign valid        = sel;
    assign rdata        = sel ? {22'b0, rx_full, tx_busy, rx_byte} : 32'b0;
    assign unused_wdata = ^wdata[31:8];

    // ------------------------------------------------------------------ TX
    uart_state_e   tx_state_q, tx_state_d;
    logic [CW-1:0] tx_baud_q,  tx_baud_d;
    logic [2:0]    tx_bit_q,   tx_bit_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          tx_q,       tx_d;

    assign tx_busy = (tx_state_q != IDLE);
    assign tx      = tx_q;

    always_comb begin
        tx_state_d = tx_state_q;
        tx_baud_d  = tx_baud_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_d       = tx_q;
        if (tx_state_q != IDLE && tx_baud_q != '0) begin
            tx_baud_d = tx_baud_q - CW'(1);
        end else begin
            case (tx_state_q)
                IDLE: begin
                    if (sel && modify == 3'b001) begin
                        tx_state_d = START;
                        tx_shift_d = wdata[7:0];
                        tx_baud_d  = BAUD_LAST;
                        tx_d       = 1'b0;
                    end
                end
                START: begin
                    tx_state_d = DATA;
                    tx_bit_d   = 3'd7;
                    tx_baud_d  = BAUD_LAST;
                    tx_d       = tx_shift_q[0];
                end
                DATA: begin
                    tx_baud_d = BAUD_LAST;
                    if (tx_bit_q == 3'd0) begin
                        tx_state_d = STOP;
                        tx_d       = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q - 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_d       = tx_shift_q[1];
                    end
                end
                default: tx_state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tx_state_q <= IDLE;
            tx_baud_q  <= '0;
            tx_bit_q   <= 3'd0;
            tx_shift_q <= 8'h00;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_baud_q  <= tx_baud_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_q       <= tx_d;
        end
    end

`ifdef CSR_UART_RX_EN
    // ------------------------------------------------------------------ RX
    uart_state_e   rx_state_q, rx_state_d;
    logic [CW-1:0] rx_baud_q,  rx_baud_d;
    logic [2:0]    rx_bit_q,   rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    rx_byte_q,  rx_byte_d;
    logic          rx_full_q,  rx_full_d;
    logic          rx_meta_q,  rx_sync_q, rx_prev_q;
    logic          rx_done;

    assign rx_full = rx_full_q;
    assign rx_byte = rx_byte_q;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_baud_d  = rx_baud_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        if (rx_state_q != IDLE && rx_baud_q != '0) begin
            rx_baud_d = rx_baud_q - CW'(1);
        end else begin
            case (rx_state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        rx_state_d = START;
                        rx_baud_d  = BAUD_HALF;
                    end
                end
                START: begin
                    // A start bit that is high again at mid-bit was a glitch
                    rx_state_d = rx_sync_q ? IDLE : DATA;
                    rx_bit_d   = 3'd7;
                    rx_baud_d  = BAUD_LAST;
                end
                DATA: begin
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_baud_d  = BAUD_LAST;
                    if (rx_bit_q == 3'd0) rx_state_d = STOP;
                    else                  rx_bit_d   = rx_bit_q - 3'd1;
                end
                default: begin
                    rx_state_d = IDLE;
                    rx_done    = rx_sync_q;
                end
            endcase
        end
        // A byte completing in the consuming cycle keeps rx_full set
        rx_byte_d = rx_done ? rx_shift_q : rx_byte_q;
        rx_full_d = rx_done ? 1'b1 : ((sel && read) ? 1'b0 : rx_full_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_state_q <= IDLE;
            rx_baud_q  <= '0;
            rx_bit_q   <= 3'd0;
            rx_shift_q <= 8'h00;
            rx_byte_q  <= 8'h00;
            rx_full_q  <= 1'b0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
        end else begin
            rx_state_q <= rx_state_d;
            rx_baud_q  <= rx_baud_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_full_q  <= rx_full_d;
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
        end
    end
`else
    logic unused_rx;

    assign unused_rx = rx;
    assign rx_full   = 1'b0;
    assign rx_byte   = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_csr_uart_char.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_uart_char
// Purpose  : Randomized scoreboard bench for csr_uart_char (DIV = 10).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_csr_uart_char;

    localparam logic [11:0] BASE  = 12'hBC0;
    localparam int          DIV   = 10;
    localparam int          FRAME = 10 * DIV;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        read = 1'b0;
    logic [2:0]  modify = 3'b000;
    logic [31:0] wdata = 32'h0;
    logic [11:0] addr = BASE;
    logic        rx = 1'b1;
    logic [31:0] rdata;
    logic        valid;
    logic        tx;

    csr_uart_char #(
        .CLOCK_RATE(1_000_000),
        .BAUD_RATE (100_000),
        .BASE_ADDR (12'hBC0)
    ) dut (
        .clk   (clk),
        .rstn  (rstn),
        .read  (read),
        .modify(modify),
        .wdata (wdata),
        .addr  (addr),
        .rdata (rdata),
        .valid (valid),
        .rx    (rx),
        .tx    (tx)
    );

    always #5 clk = ~clk;

    // Reference model state
    int          n_cmp = 0;
    int          n_fail = 0;
    longint      cyc = 0;
    longint      tx_e0 = -1000;   // edge at which the current frame began
    logic        m_full = 1'b0;
    logic [7:0]  m_byte = 8'h00;
    logic [7:0]  exp_tx[$];
    logic [31:0] exp_rd[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit m_busy();
        return (cyc >= tx_e0) && (cyc < tx_e0 + FRAME);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] act);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: got %h expected nothing (cycle %0d)", name, act, cyc);
    endtask

    // Presents one CSR access for exactly one cycle; called at posedge+1
    task automatic csr(input bit rd, input logic [2:0] mod, input logic [31:0] wd,
                       input logic [11:0] a);
        read = rd; modify = mod; wdata = wd; addr = a;
        if (a == BASE && (rd || mod != 3'b000)) begin
            if (rd) exp_rd.push_back({22'b0, m_full, m_busy(), m_byte});
            if (mod == 3'b001 && !m_busy() && rstn) begin
                exp_tx.push_back(wd[7:0]);
                tx_e0 = cyc + 1;
            end
            if (rd) m_full = 1'b0;
        end
        @(posedge clk); #1;
        read = 1'b0; modify = 3'b000; wdata = 32'h0; addr = BASE;
    endtask

    task automatic wait_cyc(input longint t);
        while (cyc < t) begin @(posedge clk); #1; end
    endtask

    task automatic rx_frame(input logic [7:0] b, input bit stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (DIV) begin @(posedge clk); #1; end
        end
        rx = 1'b1;
        repeat (2 * DIV) begin @(posedge clk); #1; end
`ifdef CSR_UART_RX_EN
        if (stop) begin m_full = 1'b1; m_byte = b; end
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tx_e0 = -1000;
        exp_tx.delete();
        m_full = 1'b0;
        m_byte = 8'h00;
        #1;
        check("reset_tx_high", {31'b0, tx}, 32'd1);
    endtask

    // CSR monitor: pops an expected read value whenever the slave answers a read
    initial begin : rd_mon
        forever begin
            @(negedge clk);
            if (addr == BASE && (read || modify != 3'b000)) begin
                check("valid_sel", {31'b0, valid}, 32'd1);
                if (read) begin
                    if (exp_rd.size() == 0) flag("rd_unexpected", rdata);
                    else check("rdata", rdata, exp_rd.pop_front());
                end
            end else begin
                check("valid_unsel", {31'b0, valid}, 32'd0);
                check("rdata_unsel", rdata, 32'd0);
            end
        end
    end

    // Line monitor: decodes each frame at mid-bit and pops the expected byte
    initial begin : tx_mon
        logic       tx_prev;
        logic [9:0] bits;
        bit         aborted;
        tx_prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rstn && tx_prev && !tx) begin
                aborted = 1'b0;
                bits    = '0;
                for (int k = 0; k < FRAME - 5; k++) begin
                    if (k != 0) @(negedge clk);
                    if (!rstn) aborted = 1'b1;
                    if (k % DIV == 4) bits[k / DIV] = tx;
                end
                if (!aborted) begin
                    if (exp_tx.size() == 0) flag("tx_unexpected_frame", {22'b0, bits});
                    else check("tx_frame", {22'b0, bits}, {22'b0, 1'b1, exp_tx.pop_front(), 1'b0});
                end
            end
            tx_prev = tx;
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        longint e0;
        logic [7:0] b;
        @(posedge clk); #1;
        do_reset();
        csr(1'b1, 3'b000, 32'h0, BASE);
        csr(1'b1, 3'b000, 32'h0, 12'hBC1);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (3) begin @(posedge clk); #1; end

        // Frame 0x55, busy window edges and a write in the cycle busy drops
        csr(1'b0, 3'b001, 32'hFFFF_FF55, BASE);
        e0 = tx_e0;
        csr(1'b1, 3'b000, 32'h0, BASE);
        wait_cyc(e0 + FRAME - 1);
        csr(1'b1, 3'b000, 32'h0, BASE);
        csr(1'b1, 3'b001, 32'h0000_003C, BASE);
        wait_cyc(tx_e0 + FRAME + 5);

        // Write during a frame is dropped; set/clear/no-op codes never send
        csr(1'b0, 3'b001, 32'h41, BASE);
        repeat ($urandom_range(5, 80)) begin @(posedge clk); #1; end
        csr(1'b0, 3'b001, 32'h42, BASE);
        wait_cyc(tx_e0 + FRAME);
        csr(1'b0, 3'b010, 32'hFF, BASE);
        csr(1'b0, 3'b011, 32'hFF, BASE);
        csr(1'b0, 3'b111, 32'h77, BASE);
        csr(1'b0, 3'b001, 32'h66, 12'hBC1);
        csr(1'b1, 3'b000, 32'h0, BASE);
        repeat (FRAME + 10) begin @(posedge clk); #1; end

        // Receiver: good frame, consume, framing error, glitch, overrun
        rx_frame(8'hA3, 1'b1);
        csr(1'b1, 3'b000, 32'h0, BASE);
        csr(1'b1, 3'b000, 32'h0, BASE);
        rx_frame(8'h5A, 1'b0);
        csr(1'b1, 3'b000, 32'h0, BASE);
        rx = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rx = 1'b1;
        repeat (3 * DIV) begin @(posedge clk); #1; end
        csr(1'b1, 3'b000, 32'h0, BASE);
        rx_frame(8'h11, 1'b1);
        rx_frame(8'h22, 1'b1);
        csr(1'b0, 3'b001, 32'h0, 12'hBC1);
        csr(1'b0, 3'b010, 32'hFFFF_FFFF, BASE);
        csr(1'b1, 3'b000, 32'h0, BASE);
        wait_cyc(tx_e0 + FRAME + 5);

        // Reset part-way through a frame, then a clean frame afterwards
        csr(1'b0, 3'b001, 32'hF0, BASE);
        wait_cyc(tx_e0 + 35);
        do_reset();
        csr(1'b1, 3'b000, 32'h0, BASE);
        rstn = 1'b1;
        repeat (FRAME) begin @(posedge clk); #1; end
        b = 8'($urandom);
        csr(1'b0, 3'b001, {24'h0, b}, BASE);
        csr(1'b1, 3'b000, 32'h0, BASE);
        wait_cyc(tx_e0 + FRAME + 5);

        // Randomized mix
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0: csr(1'b0, 3'b001, $urandom, BASE);
                1: csr(1'b1, 3'($urandom_range(0, 1)), $urandom, BASE);
                2: csr(1'($urandom_range(0, 1)), 3'($urandom_range(2, 7)), $urandom, BASE);
                3: repeat ($urandom_range(1, 60)) begin @(posedge clk); #1; end
                default: rx_frame(8'($urandom), $urandom_range(0, 3) != 0);
            endcase
        end
        csr(1'b1, 3'b000, 32'h0, BASE);

        wait_cyc(tx_e0 + FRAME + 10);
        repeat (10) begin @(posedge clk); #1; end
        check("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
